score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20'd1000000 (20 bits), giving the consecutive cycles a synchronized button level must hold before it is accepted.
REQ-002 The block SHALL have parameter WIN_SCORE, default 8'd11, giving the minimum score needed to win.
REQ-003 clk_i  input  1  system clock; all state updates occur on its rising edge.
REQ-004 rst_i  input  1  reset; asynchronous, active-high.
REQ-005 p1_btn_i  input  1  raw, asynchronous, bouncing player-1 point button; active-high.
REQ-006 p2_btn_i  input  1  raw, asynchronous, bouncing player-2 point button; active-high.
REQ-007 clear_btn_i  input  1  raw, asynchronous, bouncing new-game button; active-high.
REQ-008 p1_score_o  output  8  player-1 score, binary, range 0..99; feeds the display controller p1_score_i.
REQ-009 p2_score_o  output  8  player-2 score, binary, range 0..99; feeds the display controller p2_score_i.
REQ-010 point_o  output  1  one-cycle pulse when any score register changes value.
REQ-011 game_over_o  output  1  high while a winner is declared.
REQ-012 winner_o  output  2  winner code: 2'd0 = none, 2'd1 = player 1, 2'd2 = player 2.

Function
REQ-013 Each button SHALL pass through its own 2-flop synchronizer, followed by its own debouncer.
REQ-014 Each debouncer SHALL hold a debounced level and a 20-bit counter.
- Counter clears on any edge where the synchronized level equals the debounced level.
- Otherwise the counter increments.
- On the edge where it has counted DEBOUNCE_CYCLES consecutive mismatches, the debounced level flips and the counter clears.
REQ-015 A bounce shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged.
REQ-016 A rising edge of a debounced level SHALL produce an internal press event lasting exactly one cycle; falling edges produce nothing.
REQ-017 A held button SHALL produce exactly one press event, with no auto-repeat.
REQ-018 A score register SHALL update on the edge after its press event.
- Total latency from the first clock edge sampling the new raw level: 2 + DEBOUNCE_CYCLES + 1 edges.
REQ-019 A p1 press event SHALL increment p1_score_o by 1, saturating at 99; a p2 press event SHALL do the same for p2_score_o.
REQ-020 Simultaneous p1 and p2 press events in one cycle SHALL increment both scores on the same edge.
REQ-021 A clear press event SHALL set both scores to 0, game_over_o to 0 and winner_o to 0 on the next edge.
- Clear takes priority over simultaneous p1/p2 events, which are discarded.
REQ-022 The win check SHALL be evaluated on the post-update scores and registered on the same edge as the score update.
- Player N wins when score_N >= WIN_SCORE and score_N >= score_other + 2.
- On a win: game_over_o = 1 and winner_o = N.
REQ-023 While game_over_o = 1, p1/p2 press events SHALL be ignored (scores frozen); only clear or reset leaves this state.
REQ-024 At 99 with no 2-point lead (for example 99:98), further presses SHALL saturate with no win declared; point_o SHALL NOT pulse when saturation leaves the value unchanged.
REQ-025 point_o SHALL pulse on the edge that updates a score.
- It SHALL also pulse on clear when either score was nonzero.
- It SHALL be 0 in all other cycles.
REQ-026 The block SHALL implement a two-state control FSM:
- PLAYING -> OVER on a win;
- OVER -> PLAYING on clear;
- PLAYING + clear stays PLAYING with scores zeroed.

Reset
REQ-027 Asserting rst_i SHALL immediately set the following, independent of clk_i:
- scores to 0, point_o to 0, game_over_o to 0, winner_o to 0;
- FSM to PLAYING;
- all synchronizer flops, debounced levels and debounce counters to 0.
REQ-028 Reset asserted mid-debounce or mid-game SHALL discard pending presses.
- A button still held at reset release SHALL register as one press after 2 + DEBOUNCE_CYCLES + 1 edges.
REQ-029 No output SHALL change on the first clock edge after rst_i deasserts.

Verification (DEBOUNCE_CYCLES = 4, WIN_SCORE = 11)
REQ-030 Clean p1 press held for 20 cycles -> p1_score_o goes 0 to 1 exactly 7 edges after the first sampling edge, point_o pulses 1 cycle, and there is no second increment.
REQ-031 p2_btn_i toggling every 2 cycles for 30 cycles, then low -> p2_score_o stays 0 and point_o never pulses.
REQ-032 p1 and p2 pressed on the same cycle -> both scores 0 to 1 on the same edge, with a single point_o pulse.
REQ-033 Scores 10:10, then p1 scores twice -> 11:10 with no win, then 12:10 with game_over_o = 1 and winner_o = 1; a further p2 press leaves 12:10.
REQ-034 At 12:10 game over, clear press coincident with a p2 press -> scores 0:0, game_over_o = 0, winner_o = 0, point_o pulses once.
REQ-035 Preload 99:98 via presses, then extra p1 press -> p1_score_o stays 99, point_o stays 0, game_over_o stays 0.
REQ-036 rst_i asserted mid-count at 5:3 -> all outputs are 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - two-player score keeper with debounced buttons and win detection
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   p1_btn_i     raw player-1 point button (bouncing, asynchronous)
//   p2_btn_i     raw player-2 point button (bouncing, asynchronous)
//   clear_btn_i  raw new-game button (bouncing, asynchronous)
//   p1_score_o   player-1 score, 0..99
//   p2_score_o   player-2 score, 0..99
//   point_o      one-cycle pulse whenever a score register changes
//   game_over_o  high while a winner is declared
//   winner_o     0 = none, 1 = player 1, 2 = player 2

module score_keeper_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        level_d1_q;
    logic [19:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            level_d1_q <= 1'b0;
            cnt_q      <= 20'd0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            level_d1_q <= level_q;
            if (sync2_q == level_q) begin
                cnt_q <= 20'd0;
            end else if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
                // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
                level_q <= ~level_q;
                cnt_q   <= 20'd0;
            end else begin
                cnt_q <= cnt_q + 20'd1;
            end
        end
    end

    // Rising edge of the debounced level only; a held button yields one pulse.
    assign press_o = level_q & ~level_d1_q;

endmodule

module score_keeper #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [7:0]  WIN_SCORE       = 8'd11
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       p1_btn_i,
    input  logic       p2_btn_i,
    input  logic       clear_btn_i,
    output logic [7:0] p1_score_o,
    output logic [7:0] p2_score_o,
    output logic       point_o,
    output logic       game_over_o,
    output logic [1:0] winner_o
);

    localparam logic [7:0] MAX_SCORE = 8'd99;

    typedef enum logic {
        PLAYING = 1'b0,
        OVER    = 1'b1
    } state_t;

    logic p1_ev;
    logic p2_ev;
    logic clr_ev;

    score_keeper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (p1_btn_i),
        .press_o (p1_ev)
    );

    score_keeper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (p2_btn_i),
        .press_o (p2_ev)
    );

    score_keeper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (clear_btn_i),
        .press_o (clr_ev)
    );

    state_t     state_q;
    state_t     state_d;
    logic [7:0] p1_d;
    logic [7:0] p2_d;
    logic [1:0] winner_d;
    logic       point_d;
    logic       p1_wins;
    logic       p2_wins;

    // State register plus the registered datapath it governs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= PLAYING;
            p1_score_o <= 8'd0;
            p2_score_o <= 8'd0;
            winner_o   <= 2'd0;
            point_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            p1_score_o <= p1_d;
            p2_score_o <= p2_d;
            winner_o   <= winner_d;
            point_o    <= point_d;
        end
    end

    // Next-state and next-score logic; win check uses the post-update scores.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_score_o;
        p2_d     = p2_score_o;
        winner_d = winner_o;
        point_d  = 1'b0;
        p1_wins  = 1'b0;
        p2_wins  = 1'b0;

        if (clr_ev) begin
            // Clear wins over any coincident point presses, in either state.
            state_d  = PLAYING;
            p1_d     = 8'd0;
            p2_d     = 8'd0;
            winner_d = 2'd0;
            point_d  = (p1_score_o != 8'd0) || (p2_score_o != 8'd0);
        end else if (state_q == PLAYING) begin
            if (p1_ev && (p1_score_o < MAX_SCORE)) begin
                p1_d = p1_score_o + 8'd1;
            end
            if (p2_ev && (p2_score_o < MAX_SCORE)) begin
                p2_d = p2_score_o + 8'd1;
            end
            point_d = (p1_d != p1_score_o) || (p2_d != p2_score_o);

            // 9-bit compares so score + 2 cannot wrap.
            p1_wins = (p1_d >= WIN_SCORE) && ({1'b0, p1_d} >= ({1'b0, p2_d} + 9'd2));
            p2_wins = (p2_d >= WIN_SCORE) && ({1'b0, p2_d} >= ({1'b0, p1_d} + 9'd2));
            if (p1_wins) begin
                state_d  = OVER;
                winner_d = 2'd1;
            end else if (p2_wins) begin
                state_d  = OVER;
                winner_d = 2'd2;
            end
        end
    end

    // Output decode of the FSM.
    always_comb begin
        game_over_o = (state_q == OVER);
    end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper

module tb_score_keeper;

    localparam logic [19:0] DB  = 20'd4;
    localparam logic [7:0]  WIN = 8'd11;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       p1_btn_i = 1'b0;
    logic       p2_btn_i = 1'b0;
    logic       clear_btn_i = 1'b0;
    logic [7:0] p1_score_o;
    logic [7:0] p2_score_o;
    logic       point_o;
    logic       game_over_o;
    logic [1:0] winner_o;

    score_keeper #(.DEBOUNCE_CYCLES(DB), .WIN_SCORE(WIN)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .p1_btn_i    (p1_btn_i),
        .p2_btn_i    (p2_btn_i),
        .clear_btn_i (clear_btn_i),
        .p1_score_o  (p1_score_o),
        .p2_score_o  (p2_score_o),
        .point_o     (point_o),
        .game_over_o (game_over_o),
        .winner_o    (winner_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         p1;
        int         p2;
        logic       go;
        logic [1:0] win;
    } obs_t;

    typedef struct {
        logic       p1;
        logic       p2;
        logic       clr;
        int         rep;
        int         e1;
        int         e2;
        logic       ego;
        logic [1:0] ewin;
    } vec_t;

    obs_t exp_q[$];

    // Reference model of the scores and game state.
    int         m1 = 0;
    int         m2 = 0;
    logic       mgo = 1'b0;
    logic [1:0] mwin = 2'd0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m1 = 0;
        m2 = 0;
        mgo = 1'b0;
        mwin = 2'd0;
        exp_q.delete();
    endtask

    task automatic model_apply(input logic a, input logic b, input logic c);
        int   n1;
        int   n2;
        logic pt;
        obs_t e;
        pt = 1'b0;
        if (c) begin
            pt = (m1 != 0) || (m2 != 0);
            m1 = 0;
            m2 = 0;
            mgo = 1'b0;
            mwin = 2'd0;
        end else if (!mgo) begin
            n1 = (a && m1 < 99) ? m1 + 1 : m1;
            n2 = (b && m2 < 99) ? m2 + 1 : m2;
            pt = (n1 != m1) || (n2 != m2);
            m1 = n1;
            m2 = n2;
            if (m1 >= int'(WIN) && m1 >= m2 + 2) begin
                mgo = 1'b1;
                mwin = 2'd1;
            end else if (m2 >= int'(WIN) && m2 >= m1 + 2) begin
                mgo = 1'b1;
                mwin = 2'd2;
            end
        end
        if (pt) begin
            e.p1 = m1;
            e.p2 = m2;
            e.go = mgo;
            e.win = mwin;
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every point pulse must match the oldest outstanding expectation.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && point_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_point", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pt_p1", int'(p1_score_o), e.p1);
                    check("pt_p2", int'(p2_score_o), e.p2);
                    check("pt_go", int'(game_over_o), int'(e.go));
                    check("pt_win", int'(winner_o), int'(e.win));
                end
            end
        end
    end

    task automatic do_press(input logic a, input logic b, input logic c);
        @(negedge clk_i);
        model_apply(a, b, c);
        p1_btn_i = a;
        p2_btn_i = b;
        clear_btn_i = c;
        repeat (12) @(negedge clk_i);
        p1_btn_i = 1'b0;
        p2_btn_i = 1'b0;
        clear_btn_i = 1'b0;
        repeat (12) @(negedge clk_i);
        check("missing_point", exp_q.size(), 0);
    endtask

    function automatic vec_t mk(input logic a, input logic b, input logic c, input int rep,
                                input int e1, input int e2, input logic ego, input logic [1:0] ewin);
        vec_t v;
        v.p1 = a;
        v.p2 = b;
        v.clr = c;
        v.rep = rep;
        v.e1 = e1;
        v.e2 = e2;
        v.ego = ego;
        v.ewin = ewin;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        int edge_n;

        tbl[0]  = mk(0, 0, 1, 1,   0,  0, 0, 2'd0);
        tbl[1]  = mk(1, 1, 0, 1,   1,  1, 0, 2'd0);
        tbl[2]  = mk(1, 1, 0, 9,  10, 10, 0, 2'd0);
        tbl[3]  = mk(1, 0, 0, 1,  11, 10, 0, 2'd0);
        tbl[4]  = mk(1, 0, 0, 1,  12, 10, 1, 2'd1);
        tbl[5]  = mk(0, 1, 0, 1,  12, 10, 1, 2'd1);
        tbl[6]  = mk(0, 1, 1, 1,   0,  0, 0, 2'd0);
        tbl[7]  = mk(1, 1, 0, 98, 98, 98, 0, 2'd0);
        tbl[8]  = mk(1, 0, 0, 1,  99, 98, 0, 2'd0);
        tbl[9]  = mk(1, 0, 0, 1,  99, 98, 0, 2'd0);
        tbl[10] = mk(0, 1, 0, 1,  99, 99, 0, 2'd0);
        tbl[11] = mk(0, 0, 1, 1,   0,  0, 0, 2'd0);
        tbl[12] = mk(0, 1, 0, 11,  0, 11, 1, 2'd2);
        tbl[13] = mk(0, 0, 1, 1,   0,  0, 0, 2'd0);
        tbl[14] = mk(1, 1, 0, 3,   3,  3, 0, 2'd0);
        tbl[15] = mk(1, 0, 0, 2,   5,  3, 0, 2'd0);

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_p1", int'(p1_score_o), 0);
        check("rst_p2", int'(p2_score_o), 0);
        check("rst_point", int'(point_o), 0);
        check("rst_go", int'(game_over_o), 0);
        check("rst_win", int'(winner_o), 0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // Bounce on p2 shorter than the debounce window: nothing happens.
        for (int i = 0; i < 15; i++) begin
            p2_btn_i = ~p2_btn_i;
            repeat (2) @(negedge clk_i);
        end
        p2_btn_i = 1'b0;
        repeat (15) @(negedge clk_i);
        check("bounce_p2", int'(p2_score_o), 0);

        // Clean p1 press: score changes exactly 2 + DB + 1 edges after the first sample.
        @(negedge clk_i);
        model_apply(1'b1, 1'b0, 1'b0);
        p1_btn_i = 1'b1;
        edge_n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk_i);
            #1;
            if (p1_score_o == 8'd1) begin
                edge_n = i;
                break;
            end
        end
        check("latency_edges", edge_n, 7);
        repeat (14) @(negedge clk_i);
        p1_btn_i = 1'b0;
        repeat (12) @(negedge clk_i);
        check("held_once_p1", int'(p1_score_o), 1);
        check("held_missing_point", exp_q.size(), 0);

        // Table-driven game sequences.
        for (int i = 0; i < 16; i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                do_press(tbl[i].p1, tbl[i].p2, tbl[i].clr);
            end
            check($sformatf("vec%0d_p1", i), int'(p1_score_o), tbl[i].e1);
            check($sformatf("vec%0d_p2", i), int'(p2_score_o), tbl[i].e2);
            check($sformatf("vec%0d_go", i), int'(game_over_o), int'(tbl[i].ego));
            check($sformatf("vec%0d_win", i), int'(winner_o), int'(tbl[i].ewin));
        end

        // Reset mid-debounce at 5:3: outputs clear before any clock edge.
        @(negedge clk_i);
        p1_btn_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_p1", int'(p1_score_o), 0);
        check("async_rst_p2", int'(p2_score_o), 0);
        check("async_rst_point", int'(point_o), 0);
        check("async_rst_go", int'(game_over_o), 0);
        check("async_rst_win", int'(winner_o), 0);
        model_reset();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        model_apply(1'b1, 1'b0, 1'b0);

        // Button still held at release: one press, 7 edges later, nothing on edge 1.
        edge_n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk_i);
            #1;
            if (i == 1) begin
                check("post_rst_edge1_p1", int'(p1_score_o), 0);
                check("post_rst_edge1_point", int'(point_o), 0);
            end
            if (p1_score_o == 8'd1) begin
                edge_n = i;
                break;
            end
        end
        check("post_rst_latency", edge_n, 7);
        repeat (10) @(negedge clk_i);
        p1_btn_i = 1'b0;
        repeat (12) @(negedge clk_i);
        check("post_rst_p1", int'(p1_score_o), 1);
        check("post_rst_missing_point", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
